// File: rtl/if_prefetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch prefetch unit.
package if_prefetch_unit_pkg;

    localparam int INSTR_W = 32;
    localparam int ADDR_W  = 32;

    localparam logic [ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [ADDR_W-1:0] PC_INC           = 32'd4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc_add4;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; low bits of a target are discarded.
    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return {addr[ADDR_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_unit_if.sv
// Instruction-memory request/response channel between the prefetch unit and the memory.
interface if_prefetch_unit_if;
    import if_prefetch_unit_pkg::*;

    logic               imem_req_o;
    logic [ADDR_W-1:0]  imem_addr_o;
    logic               imem_gnt_i;
    logic               imem_rvalid_i;
    logic [INSTR_W-1:0] imem_rdata_i;

    modport master (
        output imem_req_o,
        output imem_addr_o,
        input  imem_gnt_i,
        input  imem_rvalid_i,
        input  imem_rdata_i
    );

    modport slave (
        input  imem_req_o,
        input  imem_addr_o,
        output imem_gnt_i,
        output imem_rvalid_i,
        output imem_rdata_i
    );

endinterface

// File: rtl/if_prefetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush; a pop frees its slot for a push in the same cycle, even when full.
module fetch_fifo #(
    parameter  int WIDTH = 32,
    parameter  int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok_s;
    logic             pop_ok_s;

    // Status flags, accepted operations and next pointer/count state.
    always_comb begin
        empty_o   = (count_q == {CNT_W{1'b0}});
        full_o    = (count_q == CNT_W'(DEPTH));
        count_o   = count_q;
        data_o    = mem_q[rd_ptr_q];
        pop_ok_s  = pop_i && !empty_o;
        push_ok_s = push_i && (!full_o || pop_ok_s);
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (flush_i) begin
            wr_ptr_d = {PTR_W{1'b0}};
            rd_ptr_d = {PTR_W{1'b0}};
            count_d  = {CNT_W{1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_ok_s) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage write; contents need no reset because occupancy gates every read.
    always_ff @(posedge clk_i) begin
        if (push_ok_s && !flush_i) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/if_prefetch_unit.sv
// Instruction-fetch front end: owns the PC, issues credit-limited word fetches and
// buffers returned instructions with their PC+4 for the IF/ID register.
module if_prefetch_unit
    import if_prefetch_unit_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [ADDR_W-1:0] RESET_PC   = RESET_PC_DEFAULT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    if_prefetch_unit_if.master  imem,
    input  logic                redirect_i,
    input  logic [ADDR_W-1:0]   redirect_pc_i,
    input  logic                stall_i,
    output logic                if_valid_o,
    output logic [INSTR_W-1:0]  if_instr_o,
    output logic [ADDR_W-1:0]   if_pc_add4_o
);

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  outstanding_q, outstanding_d;
    logic [CNT_W-1:0]  discard_q, discard_d;

    logic [CNT_W-1:0]  data_count_s;
    logic              data_full_s;
    logic              data_empty_s;
    logic [CNT_W-1:0]  tag_count_s;
    logic              tag_full_s;
    logic              tag_empty_s;
    logic [ADDR_W-1:0] tag_head_s;
    fetch_entry_t      head_s;
    fetch_entry_t      enq_entry_s;

    logic [CNT_W:0]    credit_sum_s;
    logic              req_s;
    logic              issue_s;
    logic              keep_rsp_s;
    logic              data_push_s;
    logic              data_pop_s;
    logic              unused_s;

    // Issue/credit, response routing, dequeue and next-state of pc/outstanding/discard.
    always_comb begin
        // Buffered plus in-flight words never exceed the FIFO depth, so every response has a slot.
        credit_sum_s = {1'b0, data_count_s} + {1'b0, outstanding_q};
        req_s        = rst_i && !redirect_i && !tag_full_s
                       && (credit_sum_s < (CNT_W+1)'(FIFO_DEPTH));
        issue_s      = req_s && imem.imem_gnt_i;
        keep_rsp_s   = imem.imem_rvalid_i && (discard_q == {CNT_W{1'b0}}) && !tag_empty_s;

        if_valid_o   = !data_empty_s && !redirect_i;
        data_pop_s   = if_valid_o && !stall_i;
        data_push_s  = keep_rsp_s && !redirect_i && (!data_full_s || data_pop_s);

        enq_entry_s.instr   = imem.imem_rdata_i;
        enq_entry_s.pc_add4 = tag_head_s + PC_INC;

        imem.imem_req_o  = req_s;
        imem.imem_addr_o = pc_q;

        if (if_valid_o) begin
            if_instr_o   = head_s.instr;
            if_pc_add4_o = head_s.pc_add4;
        end else begin
            if_instr_o   = {INSTR_W{1'b0}};
            if_pc_add4_o = {ADDR_W{1'b0}};
        end

        if (redirect_i) begin
            pc_d = word_align(redirect_pc_i);
        end else if (issue_s) begin
            pc_d = pc_q + PC_INC;
        end else begin
            pc_d = pc_q;
        end

        if (issue_s && !imem.imem_rvalid_i) begin
            outstanding_d = outstanding_q + CNT_W'(1);
        end else if (!issue_s && imem.imem_rvalid_i) begin
            outstanding_d = outstanding_q - CNT_W'(1);
        end else begin
            outstanding_d = outstanding_q;
        end

        // On redirect every word still in flight becomes stale, including earlier discards.
        if (redirect_i) begin
            if (imem.imem_rvalid_i) begin
                discard_d = outstanding_q - CNT_W'(1);
            end else begin
                discard_d = outstanding_q;
            end
        end else if (imem.imem_rvalid_i && (discard_q != {CNT_W{1'b0}})) begin
            discard_d = discard_q - CNT_W'(1);
        end else begin
            discard_d = discard_q;
        end

        unused_s = ^tag_count_s;
    end

    // PC and response bookkeeping registers.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            pc_q          <= RESET_PC;
            outstanding_q <= {CNT_W{1'b0}};
            discard_q     <= {CNT_W{1'b0}};
        end else begin
            pc_q          <= pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
        end
    end

    fetch_fifo #(
        .WIDTH (INSTR_W + ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_data_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (data_push_s),
        .data_i  (enq_entry_s),
        .pop_i   (data_pop_s),
        .data_o  (head_s),
        .full_o  (data_full_s),
        .empty_o (data_empty_s),
        .count_o (data_count_s)
    );

    // Request PCs of kept (non-discarded) fetches, in issue order.
    fetch_fifo #(
        .WIDTH (ADDR_W),
        .DEPTH (FIFO_DEPTH)
    ) u_tag_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .flush_i (redirect_i),
        .push_i  (issue_s),
        .data_i  (pc_q),
        .pop_i   (keep_rsp_s),
        .data_o  (tag_head_s),
        .full_o  (tag_full_s),
        .empty_o (tag_empty_s),
        .count_o (tag_count_s)
    );

endmodule

// File: tb/tb_if_prefetch_unit.sv
// Scoreboard bench for if_prefetch_unit: a memory model answers fetches in order,
// grants push expected {instr, pc+4}, and a monitor checks each presented head.
module tb_if_prefetch_unit;
    import if_prefetch_unit_pkg::*;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        stall_i;
    logic        if_valid_o;
    logic [31:0] if_instr_o;
    logic [31:0] if_pc_add4_o;

    if_prefetch_unit_if imem_if();

    if_prefetch_unit #(.FIFO_DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .imem          (imem_if),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .stall_i       (stall_i),
        .if_valid_o    (if_valid_o),
        .if_instr_o    (if_instr_o),
        .if_pc_add4_o  (if_pc_add4_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        int          due;
    } rsp_t;

    rsp_t        pend_q[$];
    logic [63:0] exp_q[$];
    logic [31:0] model_pc = RPC;
    int          cyc = 0;
    int          lat = 1;
    int          first_gnt = -1;
    bit          gnt_slow = 1'b0;
    int          errors = 0;
    int          checks = 0;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_i      = 1'b0;
        redirect_i = 1'b0;
        @(negedge clk);
        #1;
        chk("rst_req", imem_if.imem_req_o, 64'd0);
        chk("rst_valid", if_valid_o, 64'd0);
        chk("rst_instr", if_instr_o, 64'd0);
        chk("rst_add4", if_pc_add4_o, 64'd0);
        @(negedge clk);
        rst_i     = 1'b1;
        first_gnt = -1;
    endtask

    task automatic wait_valid(input int maxc);
        int n = 0;
        #1;
        while (if_valid_o !== 1'b1 && n < maxc) begin
            tick();
            #1;
            n++;
        end
        if (if_valid_o !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL wait_valid: got no if_valid_o expected within %0d cycles", maxc);
        end
    endtask

    // Memory model: in-order responses after lat cycles; every grant is scoreboarded.
    initial begin
        imem_if.imem_gnt_i    = 1'b0;
        imem_if.imem_rvalid_i = 1'b0;
        imem_if.imem_rdata_i  = 32'h0;
        forever begin
            @(negedge clk);
            cyc++;
            if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
                imem_if.imem_rvalid_i = 1'b1;
                imem_if.imem_rdata_i  = pend_q[0].data;
                void'(pend_q.pop_front());
            end else begin
                imem_if.imem_rvalid_i = 1'b0;
                imem_if.imem_rdata_i  = 32'h0;
            end
            imem_if.imem_gnt_i = !gnt_slow || (cyc % 2 == 0);
            #1;
            if (rst_i !== 1'b1) begin
                pend_q.delete();
            end else if (imem_if.imem_req_o === 1'b1 && imem_if.imem_gnt_i) begin
                chk("gnt_addr", imem_if.imem_addr_o, model_pc);
                pend_q.push_back('{data: instr_of(imem_if.imem_addr_o), due: cyc + lat});
                exp_q.push_back({instr_of(model_pc), model_pc + 32'd4});
                model_pc = model_pc + 32'd4;
                if (first_gnt < 0) first_gnt = cyc;
            end
        end
    end

    // Monitor: compare the presented head against the scoreboard; flush on redirect/reset.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk);
            #2;
            if (rst_i !== 1'b1) begin
                exp_q.delete();
                model_pc = RPC;
            end else begin
                if (imem_if.imem_rvalid_i && !redirect_i && dut.discard_q == 3'd0) begin
                    chk("no_overflow", {63'd0, dut.data_full_s && !(if_valid_o && !stall_i)}, 64'd0);
                end
                if (redirect_i) begin
                    chk("redir_valid", if_valid_o, 64'd0);
                    exp_q.delete();
                    model_pc = {redirect_pc_i[31:2], 2'b00};
                end else if (if_valid_o === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_head", if_pc_add4_o, 64'hDEAD);
                    end else begin
                        e = exp_q[0];
                        chk("head_instr", if_instr_o, e[63:32]);
                        chk("head_add4", if_pc_add4_o, e[31:0]);
                        if (!stall_i) void'(exp_q.pop_front());
                    end
                end else begin
                    chk("idle_zero", {if_instr_o, if_pc_add4_o}, 64'd0);
                end
                chk("credit_cap", exp_q.size() <= DEPTH, 64'd1);
            end
        end
    end

    initial begin
        rst_i         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        stall_i       = 1'b0;

        // 1: streaming, first word two cycles after first grant
        lat = 1;
        do_reset();
        wait_valid(20);
        chk("t1_latency", 64'(cyc - first_gnt), 64'd2);
        chk("t1_first_add4", if_pc_add4_o, 64'h4);
        repeat (6) tick();

        // 2: stall fills exactly DEPTH words, then drains and resumes at 0x10
        stall_i = 1'b1;
        do_reset();
        repeat (10) tick();
        #1;
        chk("t2_req_off", imem_if.imem_req_o, 64'd0);
        chk("t2_valid", if_valid_o, 64'd1);
        chk("t2_head_add4", if_pc_add4_o, 64'h4);
        chk("t2_head_instr", if_instr_o, {32'd0, instr_of(32'h0)});
        tick();
        stall_i = 1'b0;
        #1;
        chk("t2_pop0", if_valid_o, 64'd1);
        tick();
        #1;
        chk("t2_resume_req", imem_if.imem_req_o, 64'd1);
        chk("t2_resume_addr", imem_if.imem_addr_o, 64'h10);
        chk("t2_pop1", if_valid_o, 64'd1);
        tick();
        #1;
        chk("t2_pop2", if_valid_o, 64'd1);
        tick();
        #1;
        chk("t2_pop3", if_valid_o, 64'd1);

        // 3: two stale responses discarded after redirect to 0x103
        lat = 3;
        do_reset();
        tick();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h103;
        #1;
        chk("t3_req_in_redir", imem_if.imem_req_o, 64'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("t3_addr", imem_if.imem_addr_o, 64'h100);
        wait_valid(20);
        chk("t3_add4", if_pc_add4_o, 64'h104);

        // 3b: back-to-back redirects with a response landing in the second one
        do_reset();
        tick();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h280;
        tick();
        redirect_pc_i = 32'h300;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("t3b_addr", imem_if.imem_addr_o, 64'h300);
        wait_valid(20);
        chk("t3b_add4", if_pc_add4_o, 64'h304);

        // 4: redirect and stall together with a full FIFO
        lat     = 1;
        stall_i = 1'b1;
        do_reset();
        repeat (8) tick();
        #1;
        chk("t4_full_valid", if_valid_o, 64'd1);
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'h200;
        #1;
        chk("t4_redir_valid", if_valid_o, 64'd0);
        chk("t4_redir_req", imem_if.imem_req_o, 64'd0);
        tick();
        redirect_i = 1'b0;
        #1;
        chk("t4_empty", if_valid_o, 64'd0);
        chk("t4_addr", imem_if.imem_addr_o, 64'h200);
        tick();
        stall_i = 1'b0;
        wait_valid(10);
        chk("t4_add4", if_pc_add4_o, 64'h204);

        // 5: PC wraps from 0xFFFFFFFC to 0
        do_reset();
        tick();
        redirect_i    = 1'b1;
        redirect_pc_i = 32'hFFFF_FFFE;
        tick();
        redirect_i = 1'b0;
        #1;
        chk("t5_addr_top", imem_if.imem_addr_o, 64'hFFFF_FFFC);
        tick();
        #1;
        chk("t5_addr_wrap", imem_if.imem_addr_o, 64'h0);
        wait_valid(10);
        chk("t5_add4_wrap", if_pc_add4_o, 64'h0);

        // 6: reset mid-operation with words buffered and in flight
        lat     = 3;
        stall_i = 1'b1;
        do_reset();
        repeat (5) tick();
        rst_i = 1'b0;
        tick();
        #1;
        chk("t6_req", imem_if.imem_req_o, 64'd0);
        chk("t6_valid", if_valid_o, 64'd0);
        chk("t6_instr", if_instr_o, 64'd0);
        chk("t6_add4", if_pc_add4_o, 64'd0);
        tick();
        rst_i   = 1'b1;
        stall_i = 1'b0;
        #1;
        chk("t6_addr", imem_if.imem_addr_o, {32'd0, RPC});

        // Mixed traffic: intermittent grants, stalls and one redirect
        lat      = 2;
        gnt_slow = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            stall_i       = (i % 5 == 3);
            redirect_i    = (i == 17);
            redirect_pc_i = 32'h400;
        end
        gnt_slow = 1'b0;
        repeat (10) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
